stress_memory_responder: RTL and testbench
==========================================

STRESS_MEMORY_RESPONDER -- requirements
Module: stress_memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to completion (legal range 1-15).
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, at least 4).
REQ-003 SHALL have parameter INIT_VALUE, default 32'h0000_0000, meaning the value loaded into every word at reset.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port nRST, input, 1, synchronous active-low reset, sampled only on the CLK rising edge.
REQ-006 SHALL have port memory_addr, input, 32, the byte address of the request.
REQ-007 SHALL have port memory_wdata, input, 32, the write data.
REQ-008 SHALL have port memory_byte_en, input, 4, the per-byte write enable for lanes [3:0].
REQ-009 SHALL have port memory_ren, input, 1, the read request.
REQ-010 SHALL have port memory_wen, input, 1, the write request.
REQ-011 SHALL have port memory_rdata, output, 32, the read data; valid only in the completion cycle.
REQ-012 SHALL have port memory_busy, output, 1, where 0 marks the completion cycle and 1 marks every other cycle.
REQ-013 SHALL have ports read_count, write_count and conflict_count, each output, 32 bits, holding statistics.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and DONE.
REQ-015 SHALL, in IDLE with ren or wen high, latch addr, wdata, byte_en and op, and load the counter with LATENCY-1.
- Goes to DONE if LATENCY=1, otherwise to WAIT.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and go to DONE when the counter reaches 1.
- Completion therefore occurs exactly LATENCY cycles after the acceptance edge.
REQ-017 SHALL, in WAIT, return to IDLE without completing (abort) if ren and wen are both low, or if addr differs from the latched addr.
- No memory update, no counter increment.
REQ-018 SHALL, in DONE, drive busy=0 for exactly one cycle and return to IDLE.
- IDLE always lasts at least one cycle, so back-to-back requests see LATENCY+1 cycles per access.
REQ-019 SHALL, in DONE for a read, drive rdata from mem[latched word index]; in all other cycles rdata SHALL be 32'h0.
REQ-020 SHALL, at the DONE edge for a write, update only the bytes whose byte_en bit is 1; other bytes SHALL be unchanged.
REQ-021 SHALL form the word index as addr[log2(DEPTH)+1:2].
- Upper address bits and addr[1:0] are ignored, so addresses wrap modulo DEPTH*4.
REQ-022 SHALL treat ren and wen both high at acceptance as a write, and increment conflict_count by 1 at acceptance.
REQ-023 SHALL increment read_count or write_count by 1 at each DONE edge according to the latched op; counters wrap from 32'hFFFF_FFFF to 0.
REQ-024 SHALL return the newly written data on a read following a write to the same word in a later transaction.
REQ-025 SHALL keep busy=1 in IDLE and WAIT, including when no request is present.

Reset
REQ-026 SHALL, while nRST=0 at a CLK edge, force state IDLE, counter 0, all statistics 0 and every memory word to INIT_VALUE.
REQ-027 SHALL drive busy=1 and rdata=32'h0 while in reset.
REQ-028 SHALL, if reset is applied mid-transaction, discard the transaction: no write commit, no busy=0 pulse.
- The first acceptance is possible on the first edge with nRST=1.

Verification
REQ-029 Reset then read: reset then read addr 0x40 (LATENCY=4) -> busy=0 exactly 4 cycles after acceptance; rdata=0x0000_0000; read_count=1.
REQ-030 Byte-enable write then read: write 0xDEADBEEF byte_en=4'b0101 to 0x10 after reset, then read 0x10 -> rdata=0x00AD00EF; write_count=1, read_count=1.
REQ-031 Address wrap: DEPTH=256; write 0x1234_5678 to 0x400, then read 0x0 -> rdata=0x1234_5678.
REQ-032 Abort: drop ren during WAIT after 2 cycles -> no busy=0 pulse, read_count unchanged; a new request is accepted from IDLE.
REQ-033 Simultaneous ren and wen: assert both with wdata=0xA5A5A5A5 at 0x8 -> conflict_count=1, write_count=1; a later read of 0x8 returns 0xA5A5A5A5.
REQ-034 Reset mid-write: assert nRST=0 in WAIT of a write to 0x20 -> no busy=0 pulse; a later read of 0x20 returns INIT_VALUE; all counters are 0.

Source files
------------

// File: rtl/stress_memory_responder.sv
// Fixed-latency memory responder used to stress bus masters: one request at a
// time, byte-enabled writes, abortable waits and running statistics counters.
module stress_memory_responder #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH      = 256,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_byte_en,
    input  logic        memory_ren,
    input  logic        memory_wen,
    output logic [31:0] memory_rdata,
    output logic        memory_busy,
    output logic [31:0] read_count,
    output logic [31:0] write_count,
    output logic [31:0] conflict_count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [3:0]  LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        wr_q, wr_d;
    logic [31:0] rd_cnt_q, wr_cnt_q, cf_cnt_q;
    logic [31:0] mem_q [DEPTH];
    logic        accept, commit, req;
    logic [AW-1:0] idx;

    assign req = memory_ren | memory_wen;
    assign idx = addr_q[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    addr_d  = memory_addr;
                    wdata_d = memory_wdata;
                    be_d    = memory_byte_en;
                    wr_d    = memory_wen;
                    cnt_d   = LOAD;
                    state_d = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                // Requester must hold the same request for the whole wait.
                if (!req || (memory_addr != addr_q)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            cf_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VALUE;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            if (accept && memory_ren && memory_wen) begin
                cf_cnt_q <= cf_cnt_q + 32'd1;
            end
            if (commit) begin
                if (wr_q) begin
                    wr_cnt_q <= wr_cnt_q + 32'd1;
                    for (int b = 0; b < 4; b++) begin
                        if (be_q[b]) begin
                            mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end else begin
                    rd_cnt_q <= rd_cnt_q + 32'd1;
                end
            end
        end
    end

    // Gated by nRST so a reset landing on the DONE cycle suppresses the pulse.
    assign memory_busy  = !(nRST && (state_q == DONE));
    assign memory_rdata = (nRST && (state_q == DONE) && !wr_q) ? mem_q[idx] : 32'h0;

    assign read_count     = rd_cnt_q;
    assign write_count    = wr_cnt_q;
    assign conflict_count = cf_cnt_q;

endmodule

// File: tb/tb_stress_memory_responder.sv
// Randomized self-checking bench for stress_memory_responder against an
// array-based model of the memory, its latency and its statistics.
module tb_stress_memory_responder;

    localparam int L = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] memory_addr, memory_wdata;
    logic [3:0]  memory_byte_en;
    logic        memory_ren, memory_wen;
    logic [31:0] memory_rdata;
    logic        memory_busy;
    logic [31:0] read_count, write_count, conflict_count;

    always #5 CLK = ~CLK;

    stress_memory_responder #(.LATENCY(L), .DEPTH(256), .INIT_VALUE(32'h0)) dut (
        .CLK(CLK), .nRST(nRST),
        .memory_addr(memory_addr), .memory_wdata(memory_wdata),
        .memory_byte_en(memory_byte_en), .memory_ren(memory_ren), .memory_wen(memory_wen),
        .memory_rdata(memory_rdata), .memory_busy(memory_busy),
        .read_count(read_count), .write_count(write_count), .conflict_count(conflict_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_mem [256];
    logic [31:0] m_rc, m_wc, m_cc;
    logic [31:0] last_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        m_rc = 0; m_wc = 0; m_cc = 0;
    endtask

    task automatic drop_req();
        memory_ren = 1'b0;
        memory_wen = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_rc"}, read_count, m_rc);
        check_eq({tag, "_wc"}, write_count, m_wc);
        check_eq({tag, "_cc"}, conflict_count, m_cc);
    endtask

    // Called at a negedge with the DUT idle. abort_at>0 aborts after that many
    // cycles; kind 0 drops the request, kind 1 changes the address.
    task automatic run_tx(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int abort_at, input int kind);
        int cyc;
        int idx;
        logic seen_done;
        memory_ren = ren; memory_wen = wen;
        memory_addr = addr; memory_wdata = wdata; memory_byte_en = be;
        idx = int'((addr >> 2) & 32'hFF);
        @(posedge CLK);
        if (ren && wen) m_cc++;
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge CLK);
            check_eq("abort_pre_busy", {31'b0, memory_busy}, 32'd1);
            if (kind == 0) drop_req();
            else memory_addr = addr ^ 32'h0000_0010;
            @(posedge CLK);
            @(negedge CLK);
            drop_req();
            seen_done = !memory_busy;
            repeat (L + 2) begin
                @(negedge CLK);
                if (!memory_busy) seen_done = 1'b1;
            end
            check_eq("abort_no_pulse", {31'b0, seen_done}, 32'd0);
            check_counters("abort");
        end else begin
            cyc = 0;
            seen_done = 1'b0;
            while (!seen_done && cyc < 40) begin
                @(negedge CLK);
                cyc++;
                if (!memory_busy) seen_done = 1'b1;
                else check_eq("wait_rdata_zero", memory_rdata, 32'h0);
            end
            check_eq("latency", cyc, L);
            last_rdata = memory_rdata;
            check_eq(wen ? "wr_rdata_zero" : "rd_data", memory_rdata, wen ? 32'h0 : model_mem[idx]);
            drop_req();
            @(posedge CLK);
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                m_wc++;
            end else begin
                m_rc++;
            end
            @(negedge CLK);
            check_eq("idle_busy", {31'b0, memory_busy}, 32'd1);
            check_counters("tx");
        end
    endtask

    initial begin
        logic [31:0] a, d;
        int r;
        nRST = 1'b0;
        drop_req();
        memory_addr = '0; memory_wdata = '0; memory_byte_en = '0;
        reset_model();
        last_rdata = '0;
        repeat (3) @(negedge CLK);
        check_eq("rst_busy", {31'b0, memory_busy}, 32'd1);
        check_eq("rst_rdata", memory_rdata, 32'h0);
        check_counters("rst");

        nRST = 1'b1;
        run_tx(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 0);
        check_eq("first_read", last_rdata, 32'h0);
        check_eq("first_rc", read_count, 32'd1);

        run_tx(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0101, 0, 0);
        run_tx(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
        check_eq("byte_en_read", last_rdata, 32'h00AD00EF);

        run_tx(1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF, 0, 0);
        run_tx(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0);
        check_eq("wrap_read", last_rdata, 32'h12345678);

        run_tx(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 2, 0);
        run_tx(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
        check_eq("post_abort_read", last_rdata, 32'h00AD00EF);

        run_tx(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, 0, 0);
        check_eq("conflict_cnt", conflict_count, 32'd1);
        run_tx(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 0);
        check_eq("conflict_read", last_rdata, 32'hA5A5A5A5);

        for (int n = 0; n < 80; n++) begin
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: run_tx(1'b1, 1'b0, a, d, 4'($urandom), 0, 0);
                4, 5, 6, 7: run_tx(1'b0, 1'b1, a, d, 4'($urandom), 0, 0);
                8:          run_tx(1'b1, 1'b1, a, d, 4'($urandom), 0, 0);
                default:    run_tx($urandom_range(0, 1) == 1, 1'b1, a, d, 4'hF,
                                   $urandom_range(1, L - 1), $urandom_range(0, 1));
            endcase
        end

        // Reset in the middle of a write wait.
        memory_ren = 1'b0; memory_wen = 1'b1;
        memory_addr = 32'h20; memory_wdata = 32'hCAFEF00D; memory_byte_en = 4'hF;
        @(posedge CLK);
        repeat (2) @(negedge CLK);
        nRST = 1'b0;
        drop_req();
        repeat (2) begin
            @(negedge CLK);
            check_eq("midrst_busy", {31'b0, memory_busy}, 32'd1);
            check_eq("midrst_rdata", memory_rdata, 32'h0);
        end
        nRST = 1'b1;
        reset_model();
        check_counters("midrst");
        run_tx(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 0);
        check_eq("midrst_read", last_rdata, 32'h0);

        // Reset landing exactly on the completion cycle of a write.
        memory_ren = 1'b0; memory_wen = 1'b1;
        memory_addr = 32'h30; memory_wdata = 32'h11223344; memory_byte_en = 4'hF;
        @(posedge CLK);
        r = 0;
        while (memory_busy && r < 40) begin
            @(negedge CLK);
            r++;
        end
        check_eq("done_rst_latency", r, L);
        nRST = 1'b0;
        #1;
        check_eq("done_rst_busy", {31'b0, memory_busy}, 32'd1);
        drop_req();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        reset_model();
        run_tx(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 0, 0);
        check_eq("done_rst_read", last_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
